instr_fetch_unit: RTL and testbench

Instruction fetch stage for the 16-bit RISC core. Sits directly downstream of the 12-bit program counter: steers the PC through its ldPC/PCinc controls, reads the 16-bit instruction at execadd from instruction memory over a req/ack handshake, and presents it to the decoder over a valid/ready handshake. Also takes branch redirects from execute and flags a sticky fault on a memory timeout.

---
 rtl/instr_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: steers the PC (ldPC/PCinc), reads the instruction at execadd over
// req/ack and hands it to the decoder over valid/ready, with redirects and timeout fault.
module instr_fetch_unit #(
  parameter int unsigned AW      = 12,
  parameter int unsigned IW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] execadd,
  output logic          ldPC,
  output logic          PCinc,
  output logic [AW-1:0] add,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_data,
  output logic [IW-1:0] ir,
  output logic [AW-1:0] ir_addr,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          fetch_fault
);

  localparam int unsigned CW = 8;
  localparam int unsigned SW = 2;
  localparam logic [CW-1:0] TMO        = CW'(TIMEOUT);
  localparam logic [SW-1:0] SETTLE_CYC = SW'(2);

  typedef enum logic [2:0] {SETTLE, FETCH, ISSUE, INC, LOAD, FAULT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] wait_q, wait_d, wait_inc;
  logic          pend_q, pend_d;
  logic [AW-1:0] target_q, target_d, redir_tgt;

  logic          ldpc_d, pcinc_d, mem_req_d, ir_valid_d, fault_d;
  logic [AW-1:0] add_d, mem_addr_d, ir_addr_d;
  logic [IW-1:0] ir_d;

  // Next state and next registered outputs; PC control defaults to hold (11).
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    wait_d     = wait_q;
    pend_d     = pend_q;
    target_d   = target_q;
    ldpc_d     = 1'b1;
    pcinc_d    = 1'b1;
    add_d      = add;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr;
    ir_d       = ir;
    ir_addr_d  = ir_addr;
    ir_valid_d = 1'b0;
    fault_d    = 1'b0;
    wait_inc   = wait_q + CW'(1);
    redir_tgt  = redirect ? redirect_addr : target_q;

    case (state_q)
      SETTLE, INC, LOAD, ISSUE: begin
        if (redirect) begin
          // Redirect beats a same-cycle ir_ready: the issued word is flushed.
          state_d = LOAD;
          ldpc_d  = 1'b1;
          pcinc_d = 1'b0;
          add_d   = redirect_addr;
        end else if (state_q == ISSUE) begin
          if (ir_ready) begin
            state_d = INC;
            ldpc_d  = 1'b0;
            pcinc_d = 1'b1;
          end else begin
            ir_valid_d = 1'b1;
          end
        end else if (state_q == SETTLE) begin
          if (settle_q == SW'(1)) begin
            state_d    = FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = execadd;
            wait_d     = '0;
            pend_d     = 1'b0;
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end else begin
          state_d  = SETTLE;
          settle_d = SETTLE_CYC;
        end
      end

      FETCH: begin
        // The request always runs to ack; a redirect only marks it for discard.
        if (redirect) begin
          pend_d   = 1'b1;
          target_d = redirect_addr;
        end
        if (mem_ack) begin
          pend_d = 1'b0;
          if (redirect || pend_q) begin
            state_d = LOAD;
            ldpc_d  = 1'b1;
            pcinc_d = 1'b0;
            add_d   = redir_tgt;
          end else begin
            state_d    = ISSUE;
            ir_d       = mem_data;
            ir_addr_d  = mem_addr;
            ir_valid_d = 1'b1;
          end
        end else if (wait_inc == TMO) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          wait_d    = wait_inc;
          mem_req_d = 1'b1;
        end
      end

      FAULT: fault_d = 1'b1;

      default: state_d = SETTLE;
    endcase
  end

  // State and output registers; reset drives {ldPC,PCinc}=00 to clear the PC.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SETTLE;
      settle_q    <= SETTLE_CYC;
      wait_q      <= '0;
      pend_q      <= 1'b0;
      target_q    <= '0;
      ldPC        <= 1'b0;
      PCinc       <= 1'b0;
      add         <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      ir          <= '0;
      ir_addr     <= '0;
      ir_valid    <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      wait_q      <= wait_d;
      pend_q      <= pend_d;
      target_q    <= target_d;
      ldPC        <= ldpc_d;
      PCinc       <= pcinc_d;
      add         <= add_d;
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
      ir          <= ir_d;
      ir_addr     <= ir_addr_d;
      ir_valid    <= ir_valid_d;
      fetch_fault <= fault_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC and memory environment, transaction-level model of
// the fetched instruction stream, directed scenarios then randomized traffic.
module tb_instr_fetch_unit;

  localparam int unsigned AW = 12;
  localparam int unsigned IW = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // main instance
  logic          reset, ldPC, PCinc, mem_req, mem_ack, ir_valid, ir_ready, redirect, fetch_fault;
  logic [AW-1:0] execadd, add, mem_addr, ir_addr, redirect_addr;
  logic [IW-1:0] mem_data, ir;
  logic [AW-1:0] pc_int = '0;

  // timeout instance (never acked)
  logic          f_reset, f_ldpc, f_pcinc, f_req, f_ack, f_valid, f_ready, f_redir, f_fault;
  logic [AW-1:0] f_execadd, f_add, f_addr, f_iraddr, f_raddr;
  logic [IW-1:0] f_data, f_ir;

  instr_fetch_unit #(.AW(AW), .IW(IW), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .execadd(execadd), .ldPC(ldPC), .PCinc(PCinc), .add(add),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .ir(ir), .ir_addr(ir_addr), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_addr(redirect_addr), .fetch_fault(fetch_fault));

  instr_fetch_unit #(.AW(AW), .IW(IW), .TIMEOUT(4)) dut_tmo (
    .clock(clock), .reset(f_reset), .execadd(f_execadd), .ldPC(f_ldpc), .PCinc(f_pcinc), .add(f_add),
    .mem_req(f_req), .mem_addr(f_addr), .mem_ack(f_ack), .mem_data(f_data),
    .ir(f_ir), .ir_addr(f_iraddr), .ir_valid(f_valid), .ir_ready(f_ready),
    .redirect(f_redir), .redirect_addr(f_raddr), .fetch_fault(f_fault));

  // Program counter: output follows its control two edges later.
  always @(posedge clock) begin
    case ({ldPC, PCinc})
      2'b00:   pc_int <= '0;
      2'b10:   pc_int <= add;
      2'b01:   pc_int <= pc_int + AW'(1);
      default: ;
    endcase
    execadd <= pc_int;
  end

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [AW-1:0] exp_next, req_addr;
  logic          flushed, issued, load_due, req_rose;
  int            accepted = 0;
  int            inc_pulses = 0;
  logic [AW-1:0] acc_addr[$];
  logic [IW-1:0] acc_data[$];

  // memory responder state
  int   wait_cnt = 0, cur_delay = 0, force_delay = -1, max_delay = 0;
  logic spurious = 1'b0;

  function automatic logic [IW-1:0] memfn(input logic [AW-1:0] a);
    return {4'hA, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: snapshot what the DUT sees, advance, update the model, drive memory.
  task automatic tick();
    logic          s_rst, s_req, s_ack, s_valid, s_ready, s_redir;
    logic [AW-1:0] s_raddr, s_maddr, s_iaddr;
    logic [IW-1:0] s_ir;
    s_rst = reset;    s_req = mem_req;     s_ack = mem_ack;   s_valid = ir_valid;
    s_ready = ir_ready; s_redir = redirect; s_raddr = redirect_addr;
    s_maddr = mem_addr; s_iaddr = ir_addr; s_ir = ir;
    @(posedge clock);
    #1;
    req_rose = 1'b0;
    if (s_rst) begin
      exp_next = '0; req_addr = '0; flushed = 1'b0; issued = 1'b0; load_due = 1'b0;
    end else begin
      if ({ldPC, PCinc} == 2'b01) inc_pulses++;
      if (s_redir) begin
        exp_next = s_raddr; flushed = 1'b1; load_due = 1'b1;
      end
      if (load_due && !(s_req && !s_ack)) begin
        check("load_ctrl", 32'({ldPC, PCinc}), 32'(2'b10));
        check("load_add", 32'(add), 32'(exp_next));
        load_due = 1'b0;
      end
      if (s_valid && s_ready && !s_redir) begin
        check("acc_clean", 32'(flushed), 32'd0);
        check("acc_once", 32'(issued), 32'd0);
        check("acc_addr", 32'(s_iaddr), 32'(req_addr));
        check("acc_data", 32'(s_ir), 32'(memfn(req_addr)));
        check("acc_inc", 32'({ldPC, PCinc}), 32'(2'b01));
        check("acc_drop", 32'(ir_valid), 32'd0);
        issued = 1'b1; exp_next = req_addr + AW'(1); accepted++;
        acc_addr.push_back(s_iaddr); acc_data.push_back(s_ir);
      end else if (s_valid && !s_redir) begin
        check("hold_valid", 32'(ir_valid), 32'd1);
        check("hold_ir", 32'(ir), 32'(s_ir));
        check("hold_addr", 32'(ir_addr), 32'(s_iaddr));
        check("hold_ctrl", 32'({ldPC, PCinc}), 32'(2'b11));
        check("hold_noreq", 32'(mem_req), 32'd0);
      end
      if (s_req && !s_ack) begin
        check("req_hold", 32'(mem_req), 32'd1);
        check("req_addr_hold", 32'(mem_addr), 32'(s_maddr));
      end
      if (mem_req && !s_req) begin
        check("fetch_addr", 32'(mem_addr), 32'(exp_next));
        req_addr = mem_addr; flushed = 1'b0; issued = 1'b0; req_rose = 1'b1;
      end
      if (flushed) check("flush_valid", 32'(ir_valid), 32'd0);
    end
    if (mem_req) begin
      mem_ack  = (wait_cnt >= cur_delay);
      mem_data = mem_ack ? memfn(mem_addr) : IW'($urandom);
      wait_cnt++;
    end else begin
      mem_ack   = spurious && ($urandom_range(0, 7) == 0);
      mem_data  = IW'($urandom);
      wait_cnt  = 0;
      cur_delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, max_delay));
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!ir_valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", 32'(ir_valid), 32'd1);
  endtask

  task automatic wait_req_start(input int budget, output int n);
    n = 0;
    req_rose = 1'b0;
    do begin
      tick();
      n++;
    end while (!req_rose && n < budget);
    check("wait_req", 32'(req_rose), 32'd1);
  endtask

  initial begin
    int n, acc_before;
    reset = 1'b1; ir_ready = 1'b1; redirect = 1'b0; redirect_addr = '0;
    mem_ack = 1'b0; mem_data = '0;
    f_reset = 1'b1; f_ack = 1'b0; f_data = '0; f_ready = 1'b1; f_redir = 1'b0;
    f_raddr = '0; f_execadd = '0;

    // reset values of both instances
    tick(); tick();
    check("rst_ctrl", 32'({ldPC, PCinc}), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_add", 32'(add), 32'd0);
    check("rst_valid", 32'(ir_valid), 32'd0);
    check("rst_ir", 32'({ir, ir_addr}), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("f_rst_out", 32'({f_ir, f_iraddr, f_valid, f_ldpc, f_pcinc}), 32'd0);
    check("f_rst_add", 32'(f_add), 32'd0);

    // timeout: no ack ever arrives
    f_reset = 1'b0;
    tick();
    check("f_settle_req", 32'(f_req), 32'd0);
    check("f_settle_ctrl", 32'({f_ldpc, f_pcinc}), 32'(2'b11));
    tick();
    check("f_req_on", 32'(f_req), 32'd1);
    check("f_req_addr", 32'(f_addr), 32'd0);
    repeat (3) tick();
    check("f_pre_fault", 32'(f_fault), 32'd0);
    check("f_pre_req", 32'(f_req), 32'd1);
    tick();
    check("f_fault_on", 32'(f_fault), 32'd1);
    check("f_fault_req", 32'(f_req), 32'd0);
    for (int i = 0; i < 6; i++) begin
      f_redir = (i % 2 == 0);
      f_raddr = AW'($urandom);
      tick();
      check("f_sticky", 32'(f_fault), 32'd1);
      check("f_sticky_req", 32'({f_req, f_valid}), 32'd0);
      check("f_sticky_ctrl", 32'({f_ldpc, f_pcinc}), 32'(2'b11));
    end
    f_redir = 1'b0;
    f_reset = 1'b1;
    tick();
    check("f_fault_clr", 32'(f_fault), 32'd0);

    // sequential fetch, zero-wait memory, decoder always ready
    reset = 1'b0;
    tick();
    check("rel_noreq", 32'(mem_req), 32'd0);
    check("rel_hold", 32'({ldPC, PCinc}), 32'(2'b11));
    tick();
    check("rel_req", 32'(mem_req), 32'd1);
    check("rel_addr", 32'(mem_addr), 32'd0);
    repeat (13) tick();
    check("seq_count", 32'(accepted), 32'd3);
    check("seq_inc", 32'(inc_pulses), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("seq_addr", 32'(acc_addr[i]), 32'(i));
      check("seq_data", 32'(acc_data[i]), 32'(memfn(AW'(i))));
    end

    // decoder stalls for 10 cycles
    ir_ready = 1'b0;
    wait_valid(10);
    repeat (10) begin
      tick();
      check("stall_valid", 32'(ir_valid), 32'd1);
      check("stall_ctrl", 32'({ldPC, PCinc}), 32'(2'b11));
      check("stall_req", 32'(mem_req), 32'd0);
    end

    // redirect wins over a same-cycle handshake
    ir_ready = 1'b1; redirect = 1'b1; redirect_addr = AW'(12'h3F0);
    tick();
    redirect = 1'b0;
    check("fl_ctrl", 32'({ldPC, PCinc}), 32'(2'b10));
    check("fl_add", 32'(add), 32'h3F0);
    check("fl_valid", 32'(ir_valid), 32'd0);
    check("fl_count", 32'(accepted), 32'd3);
    wait_req_start(10, n);
    check("fl_latency", 32'(n), 32'd3);
    check("fl_addr", 32'(mem_addr), 32'h3F0);

    // redirect during a slow fetch
    wait_valid(10);
    force_delay = 5;
    tick();
    wait_req_start(10, n);
    check("slow_addr", 32'(mem_addr), 32'h3F1);
    redirect = 1'b1; redirect_addr = AW'(12'h100);
    tick();
    redirect = 1'b0;
    repeat (4) begin
      tick();
      check("slow_req", 32'(mem_req), 32'd1);
      check("slow_valid", 32'(ir_valid), 32'd0);
    end
    tick();
    force_delay = -1;
    check("slow_drop", 32'(mem_req), 32'd0);
    check("slow_ctrl", 32'({ldPC, PCinc}), 32'(2'b10));
    check("slow_add", 32'(add), 32'h100);
    check("slow_valid2", 32'(ir_valid), 32'd0);
    wait_req_start(10, n);
    check("slow_next", 32'(mem_addr), 32'h100);
    check("slow_count", 32'(accepted), 32'd4);

    // address wrap at the top of memory
    wait_valid(10);
    check("wr_pre_addr", 32'(ir_addr), 32'h100);
    check("wr_pre_ir", 32'(ir), 32'hA100);
    redirect = 1'b1; redirect_addr = AW'(12'hFFF);
    tick();
    redirect = 1'b0;
    wait_req_start(10, n);
    check("wr_top", 32'(mem_addr), 32'hFFF);
    wait_valid(10);
    check("wr_ir", 32'(ir), 32'hAFFF);
    tick();
    wait_req_start(10, n);
    check("wr_zero", 32'(mem_addr), 32'h000);

    // randomized traffic with a mid-run reset
    acc_before = accepted;
    max_delay = 5; spurious = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        redirect = 1'b0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
      end
      ir_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(4093, 4095)) : AW'($urandom);
      tick();
    end
    redirect = 1'b0; ir_ready = 1'b1; spurious = 1'b0;
    repeat (20) tick();
    check("rand_inc", 32'(inc_pulses), 32'(accepted));
    check("rand_progress", 32'(accepted > acc_before + 50), 32'd1);
    check("rand_nofault", 32'(fetch_fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
